// File: rtl/ntt_sched_if.sv
// ntt_sched_if: requester handshake, coefficient-memory strobes and NTT control bundle.
interface ntt_sched_if #(parameter int AW = 6);
  logic [1:0] req, req_inv, grant, done;
  logic err, busy, mem_rd_en, ntt_valid_in, ntt_is_inv, ntt_valid_out, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  modport master(
    input req, req_inv, ntt_valid_out,
    output grant, done, err, busy, mem_rd_en, mem_rd_addr, ntt_valid_in, ntt_is_inv, mem_wr_en, mem_wr_addr
  );
  modport slave(
    output req, req_inv, ntt_valid_out,
    input grant, done, err, busy, mem_rd_en, mem_rd_addr, ntt_valid_in, ntt_is_inv, mem_wr_en, mem_wr_addr
  );
endinterface

// File: rtl/ntt_sched.sv
// ntt_sched: round-robin owner of the NTT pipeline, paced beat reads, result writes and job timeout.
module ntt_sched #(
  parameter int BEATS = 64,
  parameter int GAP = 3,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  ntt_sched_if.master bus
);
  localparam int AW = $clog2(BEATS);
  localparam int AW1 = AW + 1;
  localparam int GW = $clog2(GAP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state, grant;
  logic inv, last, valid_in, err;
  logic [AW-1:0] rd_cnt;
  logic [AW:0] wr_cnt;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] tcnt;
  logic active, rd, wr, rd_last, out_done, tmo, win;
  always_comb begin
    active = state == ISSUE || state == DRAIN;
    rd = state == ISSUE && gcnt == '0;
    wr = active && bus.ntt_valid_out && wr_cnt != AW1'(BEATS);
    rd_last = rd && rd_cnt == AW'(BEATS - 1);
    out_done = wr_cnt == AW1'(BEATS) || (wr && wr_cnt == AW1'(BEATS - 1));
    tmo = active && tcnt == TW'(TIMEOUT - 1);
    win = &bus.req ? !last : bus.req[1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      inv <= 1'b0;
      last <= 1'b1;
      rd_cnt <= '0;
      wr_cnt <= '0;
      gcnt <= '0;
      tcnt <= '0;
      valid_in <= 1'b0;
      err <= 1'b0;
    end else begin
      valid_in <= rd;
      gcnt <= (state == ISSUE && gcnt != GW'(GAP - 1)) ? gcnt + 1'b1 : '0;
      tcnt <= (active && !tmo) ? tcnt + 1'b1 : '0;
      if (rd) rd_cnt <= rd_cnt + 1'b1;
      if (wr) wr_cnt <= wr_cnt + 1'b1;
      if (tmo) begin
        err <= 1'b1;
        state <= IDLE;
        grant <= '0;
        inv <= 1'b0;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (|bus.req) begin
            state <= ISSUE;
            grant <= win ? 2'b10 : 2'b01;
            inv <= bus.req_inv[win];
            last <= win;
            rd_cnt <= '0;
            wr_cnt <= '0;
          end
          ISSUE: if (rd_last) state <= out_done ? DONE : DRAIN;
          DRAIN: if (out_done) state <= DONE;
          DONE: begin
            state <= IDLE;
            grant <= '0;
            inv <= 1'b0;
            wr_cnt <= '0;
          end
        endcase
      end
    end
  end
  assign bus.grant = grant;
  assign bus.done = state == DONE ? grant : 2'b00;
  assign bus.err = err;
  assign bus.busy = state != IDLE;
  assign bus.mem_rd_en = rd;
  assign bus.mem_rd_addr = rd_cnt;
  assign bus.ntt_valid_in = valid_in;
  assign bus.ntt_is_inv = inv;
  assign bus.mem_wr_en = wr;
  assign bus.mem_wr_addr = wr_cnt[AW-1:0];
endmodule
